// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Sequencer/arbiter for the single external memory bus, shared
//               between the processor core (c_*) and the program loader /
//               debug port (l_*). Serialises accesses, inserts WAIT extra
//               wait cycles, drives the pad output enable and returns read
//               data together with a one-cycle done pulse.
//
//               Two-phase clocking: all state is captured on ph2; a ph1
//               output stage presents that state on the ports during the
//               following ph1.
//
// Ports       : ph1, ph2        two-phase clock
//               reset           synchronous, active-high (sampled on ph2)
//               c_req/we/adr/wdata -> c_rdata, c_done, c_stall   core port
//               l_req/we/adr/wdata -> l_rdata, l_done            loader port
//               mem_adr, mem_we, mem_oe, mem_wdata, mem_rdata    memory pads
//               owner           current / last grant (0 core, 1 loader)
//               busy            high while an access is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int WAIT = 1
) (
    input  logic          ph1,
    input  logic          ph2,
    input  logic          reset,
    // core port
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_adr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_done,
    output logic          c_stall,
    // loader port
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_adr,
    input  logic [DW-1:0] l_wdata,
    output logic [DW-1:0] l_rdata,
    output logic          l_done,
    // memory pads
    output logic [AW-1:0] mem_adr,
    output logic          mem_we,
    output logic          mem_oe,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    // status
    output logic          owner,
    output logic          busy
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // ph2-domain state
    state_t        r_state,      w_state_nxt;
    logic [2:0]    r_cnt,        w_cnt_nxt;
    logic          r_owner,      w_owner_nxt;
    logic          r_last_owner, w_last_owner_nxt;
    logic [AW-1:0] r_adr,        w_adr_nxt;
    logic          r_we,         w_we_nxt;
    logic [DW-1:0] r_wdata,      w_wdata_nxt;
    logic [DW-1:0] r_c_rdata,    w_c_rdata_nxt;
    logic [DW-1:0] r_l_rdata,    w_l_rdata_nxt;

    // Requester chosen this cycle: the lone requester, or on a tie the one
    // that did not own the bus last (round-robin).
    logic w_pick;
    assign w_pick = (c_req & l_req) ? ~r_last_owner : l_req;

    // ------------------------------------------------------------------
    // State register (ph2)
    // ------------------------------------------------------------------
    always_ff @(posedge ph2) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;   // core wins the first tie
            r_adr        <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_c_rdata    <= '0;
            r_l_rdata    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_adr        <= w_adr_nxt;
            r_we         <= w_we_nxt;
            r_wdata      <= w_wdata_nxt;
            r_c_rdata    <= w_c_rdata_nxt;
            r_l_rdata    <= w_l_rdata_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_adr_nxt        = r_adr;
        w_we_nxt         = r_we;
        w_wdata_nxt      = r_wdata;
        w_c_rdata_nxt    = r_c_rdata;
        w_l_rdata_nxt    = r_l_rdata;

        case (r_state)
            IDLE: begin
                if (c_req | l_req) begin
                    w_state_nxt = ACCESS;
                    w_owner_nxt = w_pick;
                    w_cnt_nxt   = WAIT_LOAD;
                    if (w_pick) begin
                        w_adr_nxt   = l_adr;
                        w_we_nxt    = l_we;
                        w_wdata_nxt = l_wdata;
                    end else begin
                        w_adr_nxt   = c_adr;
                        w_we_nxt    = c_we;
                        w_wdata_nxt = c_wdata;
                    end
                end
            end

            ACCESS: begin
                if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else begin
                    // Last access cycle: memory read data is valid now.
                    if (!r_we) begin
                        if (r_owner) begin
                            w_l_rdata_nxt = mem_rdata;
                        end else begin
                            w_c_rdata_nxt = mem_rdata;
                        end
                    end
                    w_state_nxt = RESP;
                end
            end

            RESP: begin
                w_last_owner_nxt = r_owner;
                w_state_nxt      = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode and ph1 output stage
    // ------------------------------------------------------------------
    logic w_mem_we;
    logic w_c_done;
    logic w_l_done;
    logic w_busy;

    assign w_mem_we = (r_state == ACCESS) & r_we;
    assign w_c_done = (r_state == RESP) & ~r_owner;
    assign w_l_done = (r_state == RESP) &  r_owner;
    assign w_busy   = (r_state != IDLE);

    always_ff @(posedge ph1) begin
        mem_adr   <= r_adr;
        mem_wdata <= r_wdata;
        mem_we    <= w_mem_we;
        mem_oe    <= w_mem_we;
        c_done    <= w_c_done;
        l_done    <= w_l_done;
        c_rdata   <= r_c_rdata;
        l_rdata   <= r_l_rdata;
        owner     <= r_owner;
        busy      <= w_busy;
    end

    assign c_stall = c_req & ~c_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. One main
//               instance with WAIT=1 plus WAIT=0 and WAIT=7 instances for
//               latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic       ph1, ph2, reset;
    logic       c_req, c_we, l_req, l_we;
    logic [7:0] c_adr, c_wdata, l_adr, l_wdata, mem_rdata;
    logic [7:0] c_rdata, l_rdata, mem_adr, mem_wdata;
    logic       c_done, c_stall, l_done, mem_we, mem_oe, owner, busy;
    logic       lo;

    // WAIT=0 / WAIT=7 instances
    logic       a0_req, a7_req;
    logic [7:0] a0_c_rdata, a0_l_rdata, a0_mem_adr, a0_mem_wdata;
    logic [7:0] a7_c_rdata, a7_l_rdata, a7_mem_adr, a7_mem_wdata;
    logic       a0_c_done, a0_c_stall, a0_l_done, a0_mem_we, a0_mem_oe, a0_owner, a0_busy;
    logic       a7_c_done, a7_c_stall, a7_l_done, a7_mem_we, a7_mem_oe, a7_owner, a7_busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.AW(8), .DW(8), .WAIT(1)) dut (
        .ph1(ph1), .ph2(ph2), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_done(c_done), .c_stall(c_stall),
        .l_req(l_req), .l_we(l_we), .l_adr(l_adr), .l_wdata(l_wdata),
        .l_rdata(l_rdata), .l_done(l_done),
        .mem_adr(mem_adr), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    mem_port_arbiter #(.AW(8), .DW(8), .WAIT(0)) dut_w0 (
        .ph1(ph1), .ph2(ph2), .reset(reset),
        .c_req(a0_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_rdata(a0_c_rdata), .c_done(a0_c_done), .c_stall(a0_c_stall),
        .l_req(lo), .l_we(l_we), .l_adr(l_adr), .l_wdata(l_wdata),
        .l_rdata(a0_l_rdata), .l_done(a0_l_done),
        .mem_adr(a0_mem_adr), .mem_we(a0_mem_we), .mem_oe(a0_mem_oe),
        .mem_wdata(a0_mem_wdata), .mem_rdata(mem_rdata),
        .owner(a0_owner), .busy(a0_busy)
    );

    mem_port_arbiter #(.AW(8), .DW(8), .WAIT(7)) dut_w7 (
        .ph1(ph1), .ph2(ph2), .reset(reset),
        .c_req(a7_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_rdata(a7_c_rdata), .c_done(a7_c_done), .c_stall(a7_c_stall),
        .l_req(lo), .l_we(l_we), .l_adr(l_adr), .l_wdata(l_wdata),
        .l_rdata(a7_l_rdata), .l_done(a7_l_done),
        .mem_adr(a7_mem_adr), .mem_we(a7_mem_we), .mem_oe(a7_mem_oe),
        .mem_wdata(a7_mem_wdata), .mem_rdata(mem_rdata),
        .owner(a7_owner), .busy(a7_busy)
    );

    // Non-overlapping two-phase clock, 20 time-unit cycle.
    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        #5;
        forever begin
            ph1 = 1'b1; #8;
            ph1 = 1'b0; #2;
            ph2 = 1'b1; #8;
            ph2 = 1'b0; #2;
        end
    end

    // Advance to the next cycle; outputs are settled, inputs may be driven.
    task automatic step();
        @(posedge ph1);
        #3;
    endtask

    task automatic test_reset();
        reset = 1'b1; c_req = 1'b1; c_we = 1'b0; c_adr = 8'h11;
        step();                     // first reset cycle captured on ph2
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (owner !== 1'b0) begin n_fail++; $display("FAIL rst_owner: got %b expected 0", owner); end
        n_checks++; if ({mem_we, mem_oe} !== 2'b00) begin n_fail++; $display("FAIL rst_we_oe: got %b expected 00", {mem_we, mem_oe}); end
        n_checks++; if ({mem_adr, mem_wdata} !== 16'h0000) begin n_fail++; $display("FAIL rst_adr_wdata: got %h expected 0000", {mem_adr, mem_wdata}); end
        n_checks++; if ({c_rdata, l_rdata} !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0000", {c_rdata, l_rdata}); end
        n_checks++; if ({c_done, l_done} !== 2'b00) begin n_fail++; $display("FAIL rst_done: got %b expected 00", {c_done, l_done}); end
        n_checks++; if (c_stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall: got %b expected 1", c_stall); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_nogrant: got %b expected 0", busy); end
        reset = 1'b0;
        step();                     // granted in the first cycle out of reset
        n_checks++; if ({busy, owner} !== 2'b10) begin n_fail++; $display("FAIL rst_first_grant busy/owner: got %b expected 10", {busy, owner}); end
        n_checks++; if (mem_adr !== 8'h11) begin n_fail++; $display("FAIL rst_first_adr: got %h expected 11", mem_adr); end
        step();
        step();
        n_checks++; if ({c_done, c_rdata} !== {1'b1, 8'h22}) begin n_fail++; $display("FAIL rst_first_done: got %b/%h expected 1/22", c_done, c_rdata); end
        n_checks++; if (c_stall !== 1'b0) begin n_fail++; $display("FAIL rst_first_stall: got %b expected 0", c_stall); end
        step();
        c_req = 1'b0;
        n_checks++; if (c_done !== 1'b0) begin n_fail++; $display("FAIL rst_first_single: got %b expected 0", c_done); end
    endtask

    task automatic test_core_read();
        step();
        c_req = 1'b1; c_we = 1'b0; c_adr = 8'h3A; mem_rdata = 8'h5C;
        step();
        n_checks++; if ({busy, mem_adr, mem_we} !== {1'b1, 8'h3A, 1'b0}) begin n_fail++; $display("FAIL cr_acc1: got %b/%h/%b expected 1/3a/0", busy, mem_adr, mem_we); end
        c_adr = 8'hFF;              // address only needs to be valid on grant
        step();
        n_checks++; if ({mem_adr, mem_we, c_done} !== {8'h3A, 1'b0, 1'b0}) begin n_fail++; $display("FAIL cr_acc2: got %h/%b/%b expected 3a/0/0", mem_adr, mem_we, c_done); end
        step();
        n_checks++; if ({c_done, c_rdata} !== {1'b1, 8'h5C}) begin n_fail++; $display("FAIL cr_done: got %b/%h expected 1/5c", c_done, c_rdata); end
        n_checks++; if ({l_done, l_rdata} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL cr_lport: got %b/%h expected 0/00", l_done, l_rdata); end
        step();
        c_req = 1'b0;
        n_checks++; if ({c_done, busy} !== 2'b00) begin n_fail++; $display("FAIL cr_idle: got %b expected 00", {c_done, busy}); end
    endtask

    task automatic test_loader_write();
        step();
        l_req = 1'b1; l_we = 1'b1; l_adr = 8'h10; l_wdata = 8'hA7; mem_rdata = 8'hEE;
        step();
        n_checks++; if ({mem_we, mem_oe, mem_wdata, mem_adr, owner} !== {2'b11, 8'hA7, 8'h10, 1'b1}) begin n_fail++; $display("FAIL lw_acc1: got %b%b/%h/%h/%b expected 11/a7/10/1", mem_we, mem_oe, mem_wdata, mem_adr, owner); end
        l_wdata = 8'h00; l_adr = 8'h00;
        step();
        n_checks++; if ({mem_we, mem_oe, mem_wdata, mem_adr} !== {2'b11, 8'hA7, 8'h10}) begin n_fail++; $display("FAIL lw_acc2: got %b%b/%h/%h expected 11/a7/10", mem_we, mem_oe, mem_wdata, mem_adr); end
        step();
        n_checks++; if ({mem_we, mem_oe} !== 2'b00) begin n_fail++; $display("FAIL lw_resp_we: got %b expected 00", {mem_we, mem_oe}); end
        n_checks++; if ({l_done, c_done} !== 2'b10) begin n_fail++; $display("FAIL lw_done: got %b expected 10", {l_done, c_done}); end
        n_checks++; if ({c_rdata, l_rdata} !== {8'h5C, 8'h00}) begin n_fail++; $display("FAIL lw_rdata_held: got %h expected 5c00", {c_rdata, l_rdata}); end
        step();
        l_req = 1'b0;
        n_checks++; if ({l_done, mem_we, mem_adr} !== {2'b00, 8'h10}) begin n_fail++; $display("FAIL lw_idle: got %b%b/%h expected 00/10", l_done, mem_we, mem_adr); end
    endtask

    task automatic test_round_robin();
        logic       exp_own;
        logic [7:0] exp_data;
        step();
        c_req = 1'b1; l_req = 1'b1; c_we = 1'b0; l_we = 1'b0; c_adr = 8'h20; l_adr = 8'h30;
        for (int k = 0; k < 4; k++) begin
            exp_own  = (k % 2) == 1;
            exp_data = 8'h40 + 8'(k);
            step();
            mem_rdata = exp_data;
            n_checks++; if ({owner, mem_adr} !== {exp_own, (exp_own ? 8'h30 : 8'h20)}) begin n_fail++; $display("FAIL rr_grant%0d: got %b/%h expected %b", k, owner, mem_adr, exp_own); end
            step();
            step();
            n_checks++; if ({c_done, l_done} !== {~exp_own, exp_own}) begin n_fail++; $display("FAIL rr_done%0d: got %b expected %b", k, {c_done, l_done}, {~exp_own, exp_own}); end
            n_checks++; if ((exp_own ? l_rdata : c_rdata) !== exp_data) begin n_fail++; $display("FAIL rr_rdata%0d: got %h expected %h", k, (exp_own ? l_rdata : c_rdata), exp_data); end
            step();
            n_checks++; if ({c_done, l_done, busy} !== 3'b000) begin n_fail++; $display("FAIL rr_gap%0d: got %b expected 000", k, {c_done, l_done, busy}); end
        end
        c_req = 1'b0; l_req = 1'b0;
    endtask

    task automatic test_reset_abort();
        step();
        c_req = 1'b1; c_we = 1'b1; c_adr = 8'h55; c_wdata = 8'h99;
        step();
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL ab_we1: got %b expected 1", mem_we); end
        step();
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL ab_we2: got %b expected 1", mem_we); end
        reset = 1'b1;
        step();
        n_checks++; if ({mem_we, mem_oe, busy, c_done} !== 4'b0000) begin n_fail++; $display("FAIL ab_after_reset: got %b expected 0000", {mem_we, mem_oe, busy, c_done}); end
        reset = 1'b0; c_req = 1'b0;
        step();
        n_checks++; if ({c_done, busy} !== 2'b00) begin n_fail++; $display("FAIL ab_no_done: got %b expected 00", {c_done, busy}); end
        c_req = 1'b1; c_we = 1'b0; c_adr = 8'h77; mem_rdata = 8'h31;
        step();
        n_checks++; if ({busy, owner, mem_adr} !== {2'b10, 8'h77}) begin n_fail++; $display("FAIL ab_regrant: got %b%b/%h expected 10/77", busy, owner, mem_adr); end
        step();
        step();
        n_checks++; if ({c_done, c_rdata} !== {1'b1, 8'h31}) begin n_fail++; $display("FAIL ab_next_done: got %b/%h expected 1/31", c_done, c_rdata); end
        step();
        c_req = 1'b0;
    endtask

    task automatic test_latency();
        int lat0 = 0;
        int lat7 = 0;
        step();
        a0_req = 1'b1; a7_req = 1'b1; c_we = 1'b0; c_adr = 8'h66; mem_rdata = 8'h6D;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (a0_c_done && lat0 == 0) begin lat0 = i; a0_req = 1'b0; end
            if (a7_c_done && lat7 == 0) begin lat7 = i; a7_req = 1'b0; end
            if (lat0 != 0 && lat7 != 0) break;
        end
        a0_req = 1'b0; a7_req = 1'b0;
        n_checks++; if (lat0 !== 2) begin n_fail++; $display("FAIL lat_wait0: got %0d expected 2", lat0); end
        n_checks++; if (lat7 !== 9) begin n_fail++; $display("FAIL lat_wait7: got %0d expected 9", lat7); end
        n_checks++; if ({a0_c_rdata, a7_c_rdata} !== 16'h6D6D) begin n_fail++; $display("FAIL lat_rdata: got %h expected 6d6d", {a0_c_rdata, a7_c_rdata}); end
    endtask

    initial begin
        reset = 1'b1; lo = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_adr = 8'h00; c_wdata = 8'h00;
        l_req = 1'b0; l_we = 1'b0; l_adr = 8'h00; l_wdata = 8'h00;
        mem_rdata = 8'h22; a0_req = 1'b0; a7_req = 1'b0;

        test_reset();
        test_core_read();
        test_loader_write();
        test_round_robin();
        test_reset_abort();
        test_latency();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single external memory bus. It shares that bus between the processor core (instruction fetch and load/store) and the external program loader/debug port. It serialises accesses, inserts a parameterised number of wait states, controls the write-data drive enable, and returns read data with a one-cycle done pulse. It sits between the core's memory interface and the chip memory pins, clocked by the same two-phase ph1/ph2 scheme as the core.

## Interface
- AW, 8, address width
- DW, 8, data width
- WAIT, 1, extra wait cycles per access (legal 0..7)

- ph1  in  1  phase-1 clock; registered outputs update during ph1
- ph2  in  1  phase-2 clock; next state captured during ph2
- reset  in  1  reset, synchronous, active-high
- c_req  in  1  core access request; held until c_done
- c_we  in  1  core write (1) / read (0)
- c_adr  in  AW  core address
- c_wdata  in  DW  core write data
- c_rdata  out  DW  core read data, valid while c_done=1 and held afterwards
- c_done  out  1  one-cycle completion pulse to core
- c_stall  out  1  c_req & ~c_done (combinational)
- l_req, l_we, l_adr, l_wdata, l_rdata, l_done  as core set, loader port
- mem_adr  out  AW  memory address
- mem_we  out  1  memory write strobe
- mem_oe  out  1  pad drive enable for mem_wdata (equals mem_we)
- mem_wdata  out  DW  write data to pads
- mem_rdata  in  DW  read data from pads
- owner  out  1  current or last grant: 0 = core, 1 = loader
- busy  out  1  high in ACCESS and RESP

## Operation
- FSM states: IDLE, ACCESS, RESP. A 3-bit wait counter cnt.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant that requester.
  - If both are high, grant the requester not equal to last_owner (round-robin).
  - On grant, latch that requester's adr, we and wdata. Set owner, set cnt=WAIT, go to ACCESS.
- ACCESS:
  - mem_adr shows the latched address. mem_we and mem_oe show the latched we. mem_wdata shows the latched wdata.
  - While cnt≠0, decrement cnt.
  - When cnt==0:
    - For a read, capture mem_rdata into the granted port's rdata register.
    - Go to RESP.
- RESP:
  - Assert the granted port's done for exactly one cycle. Deassert mem_we and mem_oe.
  - Set last_owner=owner. Go to IDLE.
- Requester rules:
  - A requester drops req in the cycle after it sees done.
  - A req still high in IDLE is treated as a new request.
  - Deasserting req during ACCESS does not abort the access; done still pulses.
  - adr, we and wdata only need to be valid on the grant cycle.
- A write never updates either rdata register. The non-granted port's rdata is always held.
- In IDLE, mem_adr holds its last value, with mem_we=0 and mem_oe=0.
- WAIT outside 0..7 is illegal and its behaviour is unspecified.

## Timing
- One cycle is one ph1/ph2 period. State is captured on ph2 and appears on outputs during the following ph1.
- Access latency, from the grant cycle in IDLE to the done cycle, is WAIT+2 cycles.
- The request-to-request period for back-to-back accesses is WAIT+3 cycles. This covers IDLE, then WAIT+1 ACCESS cycles, then RESP.
- mem_we is high for exactly WAIT+1 consecutive cycles per write. mem_adr is stable for that whole window.
- mem_rdata is sampled in the last ACCESS cycle.
- Reset values, applied at the first cycle with reset=1:
  - state=IDLE, cnt=0, owner=0, last_owner=1 (the core wins the first tie).
  - mem_adr=0, mem_wdata=0, mem_we=0, mem_oe=0.
  - c_rdata=0, l_rdata=0, c_done=0, l_done=0, busy=0.
- Reset during ACCESS or RESP aborts the transaction. No done pulse is issued, and mem_we drops in the next cycle.
- Both done outputs are never high in the same cycle.

## Test plan
- Reset: hold reset 2 cycles with c_req=1 -> all outputs 0 and no grant. Release reset -> core granted in the first cycle.
- Core read, WAIT=1, c_adr=0x3A, mem_rdata=0x5C -> mem_adr=0x3A for 2 cycles with mem_we=0. c_done pulses on cycle 3 with c_rdata=0x5C. l_rdata unchanged.
- Loader write, WAIT=1, l_adr=0x10, l_wdata=0xA7 -> mem_we=mem_oe=1 for exactly 2 cycles with mem_wdata=0xA7. l_done pulses once. c_rdata and l_rdata unchanged.
- Both requesters held high continuously, 4 accesses -> grants alternate core, loader, core, loader. Each done is a single pulse. Period is WAIT+3 cycles.
- WAIT=0 and WAIT=7 builds, one read each -> latency is 2 and 9 cycles respectively.
- Reset asserted in the 2nd ACCESS cycle of a core write -> no c_done, mem_we=0 in the next cycle, FSM in IDLE. The next c_req completes normally.
